// File: rtl/dc_offset_estimator.sv
// dc_offset_estimator
//
// Block-average DC estimator for the AM demodulator chain. Accumulates 2^LOG2_N
// valid envelope samples and publishes their mean at each block boundary. The
// mean drives the subtrahend of the downstream subtractor, which removes the DC
// component from the audio.
//
// Parameters:
//   LOG2_N  log2 of samples per averaging block (1..16)
//   DATA_W  sample and estimate width, two's complement
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_data      signed envelope sample
//   i_valid     i_data qualifier, one sample per cycle when high
//   o_dc        signed DC estimate, held between updates
//   o_dc_valid  one-cycle pulse on the cycle o_dc takes a new value
//   o_locked    high once the first full block has completed
//
// Build option:
//   DC_ROUND_EN  when defined, the block mean rounds half toward +inf instead
//                of flooring toward -inf.

module dc_offset_estimator #(
  parameter int unsigned LOG2_N = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_dc,
  output logic              o_dc_valid,
  output logic              o_locked
);

  // Wide enough to hold 2^LOG2_N full-scale samples without overflow.
  localparam int unsigned AccW = DATA_W + LOG2_N;

  typedef enum logic [0:0] {
    StWarmup,
    StTrack
  } state_e;

  state_e                   state_q, state_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic [LOG2_N-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]        dc_q, dc_d;
  logic                     dc_valid_q, dc_valid_d;

  logic signed [AccW-1:0]   sample_ext;
  logic signed [AccW-1:0]   block_sum;
  logic [DATA_W-1:0]        block_mean;
  logic                     last_sample;

  assign sample_ext  = signed'({{LOG2_N{i_data[DATA_W-1]}}, i_data});
  // Running sum including the current sample; also the next accumulator value.
  assign block_sum   = acc_q + sample_ext;
  assign last_sample = (cnt_q == {LOG2_N{1'b1}});

`ifdef DC_ROUND_EN
  localparam logic signed [AccW-1:0] RoundBias = AccW'(1) << (LOG2_N - 1);
  // Sum plus half an LSB of the mean cannot overflow AccW bits.
  assign block_mean = DATA_W'((block_sum + RoundBias) >>> LOG2_N);
`else
  assign block_mean = DATA_W'(block_sum >>> LOG2_N);
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dc_d       = dc_q;
    dc_valid_d = 1'b0;

    if (i_valid) begin
      if (last_sample) begin
        acc_d      = '0;
        cnt_d      = '0;
        dc_d       = block_mean;
        dc_valid_d = 1'b1;
      end else begin
        acc_d = block_sum;
        cnt_d = cnt_q + LOG2_N'(1);
      end
    end

    unique case (state_q)
      StWarmup: if (i_valid && last_sample) state_d = StTrack;
      StTrack:  state_d = StTrack;
      default:  state_d = StWarmup;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StWarmup;
      acc_q      <= '0;
      cnt_q      <= '0;
      dc_q       <= '0;
      dc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dc_q       <= dc_d;
      dc_valid_q <= dc_valid_d;
    end
  end

  assign o_dc       = dc_q;
  assign o_dc_valid = dc_valid_q;
  assign o_locked   = (state_q == StTrack);

endmodule

// File: tb/tb_dc_offset_estimator.sv
module tb_dc_offset_estimator;

  localparam int unsigned LOG2_N = 4;
  localparam int unsigned DATA_W = 12;
  localparam int          N      = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] dc;
  logic              dc_valid;
  logic              locked;

  int checks = 0;
  int errors = 0;

  // Reference model state: samples seen in the open block and published results.
  int m_sum    = 0;
  int m_cnt    = 0;
  int m_dc     = 0;
  bit m_pulse  = 0;
  bit m_locked = 0;

  always #5 clk = ~clk;

  dc_offset_estimator #(
    .LOG2_N(LOG2_N),
    .DATA_W(DATA_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_valid   (valid),
    .o_dc      (dc),
    .o_dc_valid(dc_valid),
    .o_locked  (locked)
  );

  // Mean of N samples by integer division, adjusted to floor toward -inf.
  function automatic int mean_of(input int s);
    int t;
    int q;
    t = s;
`ifdef DC_ROUND_EN
    t = t + N / 2;
`endif
    q = t / N;
    if ((t % N) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  // Apply one cycle of stimulus and advance the reference model; sample #1 after edge.
  task automatic step(input bit r, input bit v, input int d);
    @(negedge clk);
    rst   = r;
    valid = v;
    data  = d[DATA_W-1:0];
    @(posedge clk);
    #1;
    m_pulse = 0;
    if (r) begin
      m_sum = 0; m_cnt = 0; m_dc = 0; m_locked = 0;
    end else if (v) begin
      m_sum = m_sum + d;
      m_cnt = m_cnt + 1;
      if (m_cnt == N) begin
        m_dc = mean_of(m_sum);
        m_pulse = 1; m_locked = 1; m_sum = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0);
    step(1, 1, 123);
    checks++;
    if (dc !== 12'd0 || dc_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset: dc=%0h dv=%0b lk=%0b required dc=0 dv=0 lk=0", dc, dc_valid, locked);
    end
  endtask

  task automatic test_const_block();
    int pulses = 0;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 100);
      pulses += int'(dc_valid);
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse || locked !== m_locked) begin
        errors++;
        $display("FAIL const_block[%0d]: dc=%0d dv=%0b lk=%0b required dc=%0d dv=%0b lk=%0b",
                 i, $signed(dc), dc_valid, locked, m_dc, m_pulse, m_locked);
      end
    end
    checks++;
    if (pulses != 1 || dc !== 12'd100 || locked !== 1'b1) begin
      errors++;
      $display("FAIL const_block_end: pulses=%0d dc=%0d lk=%0b required 1 100 1",
               pulses, $signed(dc), locked);
    end
  endtask

  task automatic test_gapped();
    int pulses = 0;
    for (int i = 0; i < 3 * N; i++) begin
      step(0, (i % 3) == 2, -5);
      pulses += int'(dc_valid);
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse || locked !== m_locked) begin
        errors++;
        $display("FAIL gapped[%0d]: dc=%0d dv=%0b lk=%0b required dc=%0d dv=%0b lk=%0b",
                 i, $signed(dc), dc_valid, locked, m_dc, m_pulse, m_locked);
      end
    end
    checks++;
    if (pulses != 1 || dc !== 12'hFFB) begin
      errors++;
      $display("FAIL gapped_end: pulses=%0d dc=%0h required 1 ffb", pulses, dc);
    end
  endtask

  task automatic test_rounding();
    logic [DATA_W-1:0] want;
`ifdef DC_ROUND_EN
    want = 12'd1;
`else
    want = 12'd0;
`endif
    for (int i = 0; i < N; i++) begin
      step(0, 1, (i < 8) ? 1 : 0);
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse) begin
        errors++;
        $display("FAIL rounding[%0d]: dc=%0d dv=%0b required dc=%0d dv=%0b",
                 i, $signed(dc), dc_valid, m_dc, m_pulse);
      end
    end
    checks++;
    if (dc !== want || dc_valid !== 1'b1) begin
      errors++;
      $display("FAIL rounding_end: dc=%0d dv=%0b required %0d 1", dc, dc_valid, want);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = -1;
    int p1 = -1;
    for (int i = 0; i < 2 * N; i++) begin
      step(0, 1, (i < N) ? 2047 : -2048);
      if (dc_valid === 1'b1) begin
        if (p0 < 0) p0 = i; else p1 = i;
        checks++;
        if (dc !== ((p1 < 0) ? 12'h7FF : 12'h800)) begin
          errors++;
          $display("FAIL b2b_value[%0d]: dc=%0h required %0h", i, dc, (p1 < 0) ? 12'h7FF : 12'h800);
        end
      end
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse || locked !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: dc=%0d dv=%0b lk=%0b required dc=%0d dv=%0b lk=1",
                 i, $signed(dc), dc_valid, locked, m_dc, m_pulse);
      end
    end
    checks++;
    if (p0 != N - 1 || p1 - p0 != N) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d gap=%0d required %0d %0d", p0, p1 - p0, N - 1, N);
    end
  endtask

  task automatic test_reset_mid_block();
    for (int i = 0; i < N + 10; i++) step(0, 1, (i < N) ? 2047 : 3);
    checks++;
    if (dc !== 12'h7FF || locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: dc=%0h lk=%0b required 7ff 1", dc, locked);
    end
    step(1, 0, 0);
    checks++;
    if (dc !== 12'd0 || locked !== 1'b0 || dc_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: dc=%0h lk=%0b dv=%0b required 0 0 0", dc, locked, dc_valid);
    end
    for (int i = 0; i < N; i++) begin
      step(0, 1, 7);
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse || locked !== m_locked) begin
        errors++;
        $display("FAIL mid_refill[%0d]: dc=%0d dv=%0b lk=%0b required dc=%0d dv=%0b lk=%0b",
                 i, $signed(dc), dc_valid, locked, m_dc, m_pulse, m_locked);
      end
    end
    checks++;
    if (dc !== 12'd7 || dc_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_refill_end: dc=%0d dv=%0b required 7 1", dc, dc_valid);
    end
  endtask

  task automatic test_reset_wins();
    for (int i = 0; i < N - 1; i++) step(0, 1, 9);
    step(1, 1, 9);
    checks++;
    if (dc_valid !== 1'b0 || dc !== 12'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: dv=%0b dc=%0h lk=%0b required 0 0 0", dc_valid, dc, locked);
    end
    // A full fresh block is required before the next pulse.
    for (int i = 0; i < N; i++) begin
      step(0, 1, 4);
      checks++;
      if (dc_valid !== ((i == N - 1) ? 1'b1 : 1'b0) || int'($signed(dc)) != m_dc) begin
        errors++;
        $display("FAIL reset_wins_refill[%0d]: dv=%0b dc=%0d required dv=%0b dc=%0d",
                 i, dc_valid, $signed(dc), (i == N - 1), m_dc);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit v;
      int d;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 4095)) - 2048;
      step(r, v, d);
      checks++;
      if (int'($signed(dc)) != m_dc || dc_valid !== m_pulse || locked !== m_locked) begin
        errors++;
        $display("FAIL random[%0d]: dc=%0d dv=%0b lk=%0b required dc=%0d dv=%0b lk=%0b",
                 i, $signed(dc), dc_valid, locked, m_dc, m_pulse, m_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_block();
    test_gapped();
    test_rounding();
    test_back_to_back();
    test_reset_mid_block();
    test_reset_wins();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
